// File: rtl/imem_dump_reader.sv
// Instruction-memory readback engine: streams COUNT words from BASE through a
// 1-cycle synchronous read port into a 2-entry valid/ready output FIFO.
module imem_dump_reader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_address,
    input  logic [LEN_W-1:0]  word_count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              dump_last,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [LEN_W-1:0]  remain_q;
    logic              infl_q;
    logic [ADDR_W-1:0] infl_addr_q;
    logic              infl_last_q;
    logic [DATA_W-1:0] fdata_q [2];
    logic [ADDR_W-1:0] faddr_q [2];
    logic              flast_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        cnt_q;
    logic              done_q;
    logic              pop;
    logic [2:0]        pending;

    assign dump_valid = (cnt_q != 2'd0);
    assign pop        = dump_valid & dump_ready;
    // Words buffered plus the read in flight, net of the word leaving this cycle.
    assign pending    = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop};
    assign rd_en      = (state_q == READ) && (remain_q != '0) && (pending < 3'd2);

    assign rd_addr   = rd_addr_q;
    assign dump_data = fdata_q[rd_ptr_q];
    assign dump_addr = faddr_q[rd_ptr_q];
    assign dump_last = flast_q[rd_ptr_q];
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            remain_q    <= '0;
            infl_q      <= 1'b0;
            infl_addr_q <= '0;
            infl_last_q <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
            done_q      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fdata_q[i] <= '0;
                faddr_q[i] <= '0;
                flast_q[i] <= 1'b0;
            end
        end else begin
            done_q <= 1'b0;
            infl_q <= rd_en;
            if (rd_en) begin
                infl_addr_q <= rd_addr_q;
                infl_last_q <= (remain_q == LEN_W'(1));
                rd_addr_q   <= rd_addr_q + ADDR_W'(1);
                remain_q    <= remain_q - LEN_W'(1);
            end
            if (infl_q) begin
                fdata_q[wr_ptr_q] <= rd_data;
                faddr_q[wr_ptr_q] <= infl_addr_q;
                flast_q[wr_ptr_q] <= infl_last_q;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, infl_q} - {1'b0, pop};

            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (word_count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            rd_addr_q <= base_address;
                            remain_q  <= word_count;
                            state_q   <= READ;
                        end
                    end
                end
                READ: begin
                    if (rd_en && remain_q == LEN_W'(1)) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (pop && flast_q[rd_ptr_q]) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_dump_reader.sv
// Self-checking bench for imem_dump_reader: memory model, per-scenario tasks,
// expected beats derived from base/count arithmetic over the memory image.
module tb_imem_dump_reader;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int LW = 13;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_address;
    logic [LW-1:0] word_count;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          dump_valid;
    logic          dump_ready;
    logic [DW-1:0] dump_data;
    logic [AW-1:0] dump_addr;
    logic          dump_last;
    logic          busy;
    logic          done;

    imem_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .base_address(base_address), .word_count(word_count),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_data(dump_data), .dump_addr(dump_addr), .dump_last(dump_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [4096];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int tests = 0;
    int fails = 0;

    // ready pattern 1,0,0,1,0,0,0,0,0,1,0,1 indexed by bit position
    logic [11:0] pat = 12'b1010_0000_1001;

    int            g_addr[$];
    logic [DW-1:0] g_data[$];
    bit            g_last[$];
    int            g_cyc[$];
    int            g_rdaddr[$];
    int            e_addr[$];
    logic [DW-1:0] e_data[$];
    bit            e_last[$];
    int done_cyc, first_rd, rd_cnt, stall_err, full_err, busy_err, valid_seen;
    bit timeout;

    function automatic void build_exp(input int base, input int cnt);
        e_addr.delete(); e_data.delete(); e_last.delete();
        for (int i = 0; i < cnt; i++) begin
            int a;
            a = (base + i) % 4096;
            e_addr.push_back(a);
            e_data.push_back(mem[a]);
            e_last.push_back(i == cnt - 1);
        end
    endfunction

    task automatic do_start(input int b, input int n);
        base_address = b[AW-1:0];
        word_count   = n[LW-1:0];
        start        = 1'b1;
    endtask

    // Runs cycles after a start, recording beats and protocol observations.
    task automatic collect(input int maxc, input int mode, input int stop_beats,
                           input int xcyc, input int xb, input int xn);
        int outstanding, p;
        bit pv, pr, pl, r;
        logic [DW-1:0] pd;
        logic [AW-1:0] pa;
        g_addr.delete(); g_data.delete(); g_last.delete(); g_cyc.delete(); g_rdaddr.delete();
        done_cyc = -1; first_rd = -1; rd_cnt = 0; stall_err = 0; full_err = 0;
        busy_err = 0; valid_seen = 0; timeout = 1; outstanding = 0;
        pv = 0; pr = 0; pl = 0; pd = '0; pa = '0;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == xcyc) do_start(xb, xn);
            case (mode)
                0:       r = 1'b1;
                1:       r = pat[c % 12];
                default: r = ($urandom_range(0, 2) != 0);
            endcase
            dump_ready = r;
            #1;
            if (pv && !pr && (!dump_valid || dump_data !== pd || dump_addr !== pa || dump_last !== pl))
                stall_err++;
            if (done) begin
                done_cyc = c; timeout = 0;
                if (busy) busy_err++;
                break;
            end
            if (!busy) busy_err++;
            if (dump_valid) valid_seen++;
            p = (dump_valid && dump_ready) ? 1 : 0;
            if (rd_en) begin
                rd_cnt++;
                g_rdaddr.push_back(int'(rd_addr));
                if (first_rd < 0) first_rd = c;
                if (outstanding - p >= 2) full_err++;
                outstanding++;
            end
            if (p == 1) begin
                g_addr.push_back(int'(dump_addr));
                g_data.push_back(dump_data);
                g_last.push_back(dump_last);
                g_cyc.push_back(c);
                outstanding--;
            end
            pv = dump_valid; pr = dump_ready; pd = dump_data; pa = dump_addr; pl = dump_last;
            if (stop_beats > 0 && g_addr.size() == stop_beats) begin
                timeout = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        tests++;
        if (rd_en !== 0 || rd_addr !== 0 || dump_valid !== 0 || dump_data !== 0 ||
            dump_addr !== 0 || dump_last !== 0 || busy !== 0 || done !== 0) begin
            fails++;
            $display("FAIL reset_state got rd_en=%b rd_addr=%0d v=%b d=%h a=%0d l=%b busy=%b done=%b exp all 0",
                     rd_en, rd_addr, dump_valid, dump_data, dump_addr, dump_last, busy, done);
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        mem[0] = 32'h20080005; mem[1] = 32'h2009000A; mem[2] = 32'h01095020;
        do_start(0, 3);
        collect(50, 0, 0, 0, 0, 0);
        build_exp(0, 3);
        tests++;
        if (timeout || g_addr.size() != 3) begin
            fails++; $display("FAIL basic_beats got %0d beats timeout=%0b exp 3", g_addr.size(), timeout);
        end
        foreach (e_addr[i]) if (i < g_addr.size()) begin
            tests++;
            if (g_addr[i] !== e_addr[i] || g_data[i] !== e_data[i] || g_last[i] !== e_last[i] || g_cyc[i] != 3 + i) begin
                fails++;
                $display("FAIL basic_beat%0d got a=%0d d=%h l=%0b cyc=%0d exp a=%0d d=%h l=%0b cyc=%0d",
                         i, g_addr[i], g_data[i], g_last[i], g_cyc[i], e_addr[i], e_data[i], e_last[i], 3 + i);
            end
        end
        tests++;
        if (done_cyc != 6 || first_rd != 1 || busy_err != 0) begin
            fails++; $display("FAIL basic_timing got done=%0d first_rd=%0d busy_err=%0d exp 6 1 0", done_cyc, first_rd, busy_err);
        end
    endtask

    task automatic test_zero_count();
        @(negedge clk);
        do_start(5, 0);
        collect(20, 0, 0, 0, 0, 0);
        tests++;
        if (done_cyc != 1 || rd_cnt != 0 || valid_seen != 0) begin
            fails++; $display("FAIL zero_count got done=%0d rd=%0d valid=%0d exp 1 0 0", done_cyc, rd_cnt, valid_seen);
        end
        repeat (3) begin
            @(negedge clk); #1;
            tests++;
            if (rd_en !== 0 || dump_valid !== 0 || busy !== 0 || done !== 0) begin
                fails++; $display("FAIL zero_after got rd=%b v=%b busy=%b done=%b exp 0", rd_en, dump_valid, busy, done);
            end
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        do_start(4094, 4);
        collect(50, 0, 0, 0, 0, 0);
        build_exp(4094, 4);
        tests++;
        if (timeout || g_rdaddr.size() != 4 || g_addr.size() != 4) begin
            fails++; $display("FAIL wrap_count got rd=%0d beats=%0d exp 4 4", g_rdaddr.size(), g_addr.size());
        end
        foreach (e_addr[i]) if (i < g_addr.size() && i < g_rdaddr.size()) begin
            tests++;
            if (g_rdaddr[i] !== e_addr[i] || g_addr[i] !== e_addr[i] || g_data[i] !== e_data[i] || g_last[i] !== e_last[i]) begin
                fails++;
                $display("FAIL wrap_beat%0d got rd_addr=%0d a=%0d d=%h l=%0b exp a=%0d d=%h l=%0b",
                         i, g_rdaddr[i], g_addr[i], g_data[i], g_last[i], e_addr[i], e_data[i], e_last[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        do_start(200, 8);
        collect(200, 1, 0, 0, 0, 0);
        build_exp(200, 8);
        tests++;
        if (timeout || g_addr.size() != 8 || rd_cnt != 8) begin
            fails++; $display("FAIL bp_count got beats=%0d rd=%0d timeout=%0b exp 8 8", g_addr.size(), rd_cnt, timeout);
        end
        foreach (e_addr[i]) if (i < g_addr.size()) begin
            tests++;
            if (g_addr[i] !== e_addr[i] || g_data[i] !== e_data[i] || g_last[i] !== e_last[i]) begin
                fails++;
                $display("FAIL bp_beat%0d got a=%0d d=%h l=%0b exp a=%0d d=%h l=%0b",
                         i, g_addr[i], g_data[i], g_last[i], e_addr[i], e_data[i], e_last[i]);
            end
        end
        tests++;
        if (full_err != 0 || stall_err != 0 || busy_err != 0) begin
            fails++; $display("FAIL bp_protocol got full=%0d stall=%0d busy=%0d exp 0 0 0", full_err, stall_err, busy_err);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 5; k++) begin
            int b, n;
            b = $urandom_range(0, 4095);
            n = $urandom_range(1, 24);
            @(negedge clk);
            do_start(b, n);
            collect(600, 2, 0, 0, 0, 0);
            build_exp(b, n);
            tests++;
            if (timeout || g_addr.size() != n || full_err != 0 || stall_err != 0 || busy_err != 0) begin
                fails++;
                $display("FAIL rand%0d got beats=%0d exp %0d timeout=%0b full=%0d stall=%0d busy=%0d",
                         k, g_addr.size(), n, timeout, full_err, stall_err, busy_err);
            end
            foreach (e_addr[i]) if (i < g_addr.size()) begin
                tests++;
                if (g_addr[i] !== e_addr[i] || g_data[i] !== e_data[i] || g_last[i] !== e_last[i]) begin
                    fails++;
                    $display("FAIL rand%0d_beat%0d got a=%0d d=%h l=%0b exp a=%0d d=%h l=%0b",
                             k, i, g_addr[i], g_data[i], g_last[i], e_addr[i], e_data[i], e_last[i]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        do_start(50, 6);
        collect(50, 0, 2, 0, 0, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        tests++;
        if (rd_en !== 0 || rd_addr !== 0 || dump_valid !== 0 || dump_data !== 0 ||
            dump_addr !== 0 || dump_last !== 0 || busy !== 0 || done !== 0) begin
            fails++;
            $display("FAIL async_reset got rd_en=%b rd_addr=%0d v=%b d=%h a=%0d l=%b busy=%b done=%b exp all 0",
                     rd_en, rd_addr, dump_valid, dump_data, dump_addr, dump_last, busy, done);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (rd_en !== 0 || dump_valid !== 0 || busy !== 0) begin
            fails++; $display("FAIL post_reset_idle got rd=%b v=%b busy=%b exp 0", rd_en, dump_valid, busy);
        end
        @(negedge clk);
        do_start(10, 2);
        collect(50, 0, 0, 0, 0, 0);
        build_exp(10, 2);
        tests++;
        if (timeout || g_addr.size() != 2) begin
            fails++; $display("FAIL reset_restart got %0d beats exp 2", g_addr.size());
        end
        foreach (e_addr[i]) if (i < g_addr.size()) begin
            tests++;
            if (g_addr[i] !== e_addr[i] || g_data[i] !== e_data[i] || g_last[i] !== e_last[i]) begin
                fails++;
                $display("FAIL reset_restart_beat%0d got a=%0d d=%h l=%0b exp a=%0d d=%h l=%0b",
                         i, g_addr[i], g_data[i], g_last[i], e_addr[i], e_data[i], e_last[i]);
            end
        end
    endtask

    task automatic test_busy_start();
        @(negedge clk);
        do_start(100, 5);
        collect(80, 0, 0, 2, 700, 3);
        build_exp(100, 5);
        tests++;
        if (timeout || g_addr.size() != 5 || rd_cnt != 5) begin
            fails++; $display("FAIL busy_start_count got beats=%0d rd=%0d exp 5 5", g_addr.size(), rd_cnt);
        end
        foreach (e_addr[i]) if (i < g_addr.size()) begin
            tests++;
            if (g_addr[i] !== e_addr[i] || g_data[i] !== e_data[i] || g_last[i] !== e_last[i]) begin
                fails++;
                $display("FAIL busy_start_beat%0d got a=%0d d=%h l=%0b exp a=%0d d=%h l=%0b",
                         i, g_addr[i], g_data[i], g_last[i], e_addr[i], e_data[i], e_last[i]);
            end
        end
        // collect returns inside the done cycle; start now is sampled at its end
        do_start(300, 2);
        collect(50, 0, 0, 0, 0, 0);
        build_exp(300, 2);
        tests++;
        if (timeout || first_rd != 1 || g_addr.size() != 2) begin
            fails++; $display("FAIL done_cycle_start got first_rd=%0d beats=%0d exp 1 2", first_rd, g_addr.size());
        end
        foreach (e_addr[i]) if (i < g_addr.size()) begin
            tests++;
            if (g_addr[i] !== e_addr[i] || g_data[i] !== e_data[i] || g_last[i] !== e_last[i]) begin
                fails++;
                $display("FAIL done_cycle_beat%0d got a=%0d d=%h l=%0b exp a=%0d d=%h l=%0b",
                         i, g_addr[i], g_data[i], g_last[i], e_addr[i], e_data[i], e_last[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        reset = 1'b0; start = 1'b0; base_address = '0; word_count = '0; dump_ready = 1'b0;
        #1 reset = 1'b1;
        #2;
        test_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_basic();
        test_zero_count();
        test_wrap();
        test_backpressure();
        test_random();
        test_async_reset();
        test_busy_start();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1);
    end
endmodule
